npu_spi_slave_if: RTL and testbench

//  SPI slave front-end between the board pins (sclk/mosi/cs_n/miso) and the NPU command path, running on rpll_clk.

---
 rtl/npu_spi_pkg.sv | 14 +
 rtl/npu_pin_sync.sv | 24 ++
 rtl/npu_spi_slave_if.sv | 204 ++++++++++++++++++++
 tb/tb_npu_spi_slave_if.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/npu_spi_pkg.sv
// Shared SPI front-end types and constants for the NPU command path.
package npu_spi_pkg;

  localparam int SPI_DATA_W = 8;

  localparam logic [SPI_DATA_W-1:0] SPI_FILL_BYTE = 8'h00;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    ACTIVE
  } spi_state_e;

endpackage

// File: rtl/npu_pin_sync.sv
// Multi-stage synchroniser for one asynchronous pin, with a configurable reset level.
module npu_pin_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic rpll_clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge rpll_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/npu_spi_slave_if.sv
// SPI mode-0 slave: oversampled pins, MOSI deserialiser to a valid/ready stream,
// valid/ready response stream serialised onto MISO through a single holding register.
module npu_spi_slave_if
  import npu_spi_pkg::*;
#(
  parameter int                DATA_W      = SPI_DATA_W,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] FILL_BYTE   = SPI_FILL_BYTE
) (
  input  logic              rpll_clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              cs_n,
  output logic              miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              frame_start,
  output logic              frame_end,
  output logic              rx_overrun,
  output logic              tx_underrun
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  logic sclk_s, mosi_s, cs_n_s;
  logic sclk_prev_q, cs_n_prev_q;
  logic sclk_rise, sclk_fall, cs_n_fall, cs_n_rise;

  npu_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .rpll_clk(rpll_clk), .rst_n(rst_n), .d_i(sclk), .q_o(sclk_s)
  );
  npu_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .rpll_clk(rpll_clk), .rst_n(rst_n), .d_i(mosi), .q_o(mosi_s)
  );
  npu_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
    .rpll_clk(rpll_clk), .rst_n(rst_n), .d_i(cs_n), .q_o(cs_n_s)
  );

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_n_fall = ~cs_n_s & cs_n_prev_q;
  assign cs_n_rise = cs_n_s & ~cs_n_prev_q;

  spi_state_e          state_q, state_d;
  logic [SYNC_STAGES:0] settle_q;
  logic                settled;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-2:0]   rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]   rx_word;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0]   tx_hold_q, tx_hold_d;
  logic                hold_full_q, hold_full_d;
  logic                miso_q, miso_d;
  logic                frame_start_q, frame_start_d;
  logic                frame_end_q, frame_end_d;
  logic                rx_overrun_q, rx_overrun_d;
  logic                tx_underrun_q, tx_underrun_d;
  logic                load_tx;

  // The synchronisers power up at idle levels; trust cs_n only once real pin values have flushed through.
  assign settled = settle_q[SYNC_STAGES];
  assign rx_word = {rx_shift_q, mosi_s};

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    tx_shift_d    = tx_shift_q;
    tx_hold_d     = tx_hold_q;
    hold_full_d   = hold_full_q;
    miso_d        = miso_q;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    rx_overrun_d  = 1'b0;
    tx_underrun_d = 1'b0;
    load_tx       = 1'b0;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      WAIT_IDLE: begin
        if (settled && cs_n_s) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (cs_n_fall) begin
          state_d       = ACTIVE;
          frame_start_d = 1'b1;
          bit_cnt_d     = '0;
          load_tx       = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_n_rise) begin
          state_d     = IDLE;
          frame_end_d = 1'b1;
          bit_cnt_d   = '0;
          miso_d      = 1'b0;
        end else begin
          if (sclk_rise) begin
            rx_shift_d = rx_word[DATA_W-2:0];
            if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
              bit_cnt_d = '0;
              if (!rx_valid_q || rx_ready) begin
                rx_data_d  = rx_word;
                rx_valid_d = 1'b1;
              end else begin
                rx_overrun_d = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
          if (sclk_fall) begin
            if (bit_cnt_q == '0) begin
              load_tx = 1'b1;
            end else begin
              tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
              miso_d     = tx_shift_q[DATA_W-2];
            end
          end
        end
      end
      default: state_d = WAIT_IDLE;
    endcase

    if (load_tx) begin
      if (hold_full_q) begin
        tx_shift_d  = tx_hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_shift_d    = FILL_BYTE;
        tx_underrun_d = 1'b1;
      end
      miso_d = tx_shift_d[DATA_W-1];
    end

    // Only accepted while empty, so a same-cycle copy always took the old content or the fill word.
    if (tx_valid && !hold_full_q) begin
      tx_hold_d   = tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge rpll_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WAIT_IDLE;
      settle_q      <= '0;
      sclk_prev_q   <= 1'b0;
      cs_n_prev_q   <= 1'b1;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_shift_q    <= '0;
      tx_hold_q     <= '0;
      hold_full_q   <= 1'b0;
      miso_q        <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      settle_q      <= {settle_q[SYNC_STAGES-1:0], 1'b1};
      sclk_prev_q   <= sclk_s;
      cs_n_prev_q   <= cs_n_s;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_shift_q    <= tx_shift_d;
      tx_hold_q     <= tx_hold_d;
      hold_full_q   <= hold_full_d;
      miso_q        <= miso_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  assign miso        = miso_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_ready    = ~hold_full_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign rx_overrun  = rx_overrun_q;
  assign tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_npu_spi_slave_if.sv
// Directed bench for npu_spi_slave_if: SPI host at rpll_clk/8 plus stream-side handshakes.
module tb_npu_spi_slave_if;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       cs_n = 1'b1;
  logic       miso;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       frame_start, frame_end, rx_overrun, tx_underrun;

  logic [7:0] tx_data_man = 8'h00;
  logic       tx_valid_man = 1'b0;
  logic       auto_tx = 1'b0;
  int         tx_base = 0;

  int tests = 0;
  int fails = 0;

  int fs_cnt = 0, fe_cnt = 0, ov_cnt = 0, un_cnt = 0, tx_sent = 0, rx_n = 0;
  int under_snap = 0;
  logic [7:0] rx_log [64];

  always #5 clk = ~clk;

  // In auto mode the bench offers 0x01, 0x02, ... advancing on each accepted word.
  assign tx_valid = auto_tx | tx_valid_man;
  assign tx_data  = auto_tx ? 8'(tx_sent - tx_base + 1) : tx_data_man;

  npu_spi_slave_if dut (
    .rpll_clk   (clk),
    .rst_n      (rst_n),
    .sclk       (sclk),
    .mosi       (mosi),
    .cs_n       (cs_n),
    .miso       (miso),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .frame_start(frame_start),
    .frame_end  (frame_end),
    .rx_overrun (rx_overrun),
    .tx_underrun(tx_underrun)
  );

  always @(posedge clk) begin
    if (frame_start) fs_cnt <= fs_cnt + 1;
    if (frame_end) fe_cnt <= fe_cnt + 1;
    if (rx_overrun) ov_cnt <= ov_cnt + 1;
    if (tx_underrun) un_cnt <= un_cnt + 1;
    if (tx_valid && tx_ready) tx_sent <= tx_sent + 1;
    if (rx_valid && rx_ready && rx_n < 64) begin
      rx_log[rx_n] <= rx_data;
      rx_n         <= rx_n + 1;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("[TB] check %s observed %0h expected %0h", tag, obs, exp);
  endtask

  // Mode 0 host: MOSI changes with sclk low, MISO sampled just before each rise.
  task automatic spi_xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = mo[i];
      wait_clk(4);
      mi[i] = miso;
      sclk = 1'b1;
      wait_clk(4);
      if (i == 0) under_snap = un_cnt;
      sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    wait_clk(6);
  endtask

  task automatic cs_high();
    wait_clk(4);
    cs_n = 1'b1;
    wait_clk(6);
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    wait_clk(1);
    rx_ready = 1'b0;
    wait_clk(1);
  endtask

  initial begin
    logic [7:0] mi0, mi1, mi2;
    int fs0, fe0, ov0, un0, rxn0;

    wait_clk(3);
    chk("rst_miso", miso, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_frame_end", frame_end, 0);
    chk("rst_rx_overrun", rx_overrun, 0);
    chk("rst_tx_underrun", tx_underrun, 0);
    rst_n = 1'b1;
    wait_clk(8);

    // Single 0xA5 frame, nothing to transmit
    fs0 = fs_cnt; fe0 = fe_cnt;
    cs_low(); spi_xfer(8'hA5, 8, mi0); cs_high();
    chk("t1_rx_data", rx_data, 8'hA5);
    chk("t1_rx_valid", rx_valid, 1);
    chk("t1_frame_start", fs_cnt - fs0, 1);
    chk("t1_frame_end", fe_cnt - fe0, 1);
    chk("t1_miso_fill", mi0, 8'h00);
    drain();
    chk("t1_rx_consumed", rx_valid, 0);

    // 0x3C queued before the frame, then fill byte
    tx_data_man = 8'h3C; tx_valid_man = 1'b1;
    wait_clk(1);
    tx_valid_man = 1'b0;
    chk("t2_tx_ready_full", tx_ready, 0);
    rx_ready = 1'b1;
    un0 = un_cnt;
    cs_low(); spi_xfer(8'h00, 8, mi0); spi_xfer(8'h00, 8, mi1); cs_high();
    rx_ready = 1'b0;
    chk("t2_miso_b0", mi0, 8'h3C);
    chk("t2_miso_b1", mi1, 8'h00);
    chk("t2_underrun_b1", under_snap - un0, 1);
    chk("t2_tx_ready_free", tx_ready, 1);
    chk("t2_rx_valid", rx_valid, 0);

    // Consumer stalled across three words
    ov0 = ov_cnt;
    cs_low(); spi_xfer(8'h11, 8, mi0); spi_xfer(8'h22, 8, mi0); spi_xfer(8'h33, 8, mi0); cs_high();
    chk("t3_rx_data", rx_data, 8'h11);
    chk("t3_rx_valid", rx_valid, 1);
    chk("t3_overruns", ov_cnt - ov0, 2);
    drain();

    // Frame aborted after 5 bits, then a clean frame
    ov0 = ov_cnt;
    cs_low(); spi_xfer(8'hFF, 5, mi0); cs_high();
    chk("t4_no_rx_valid", rx_valid, 0);
    chk("t4_miso_idle", miso, 0);
    chk("t4_no_overrun", ov_cnt - ov0, 0);
    cs_low(); spi_xfer(8'h81, 8, mi0); cs_high();
    chk("t4_rx_data", rx_data, 8'h81);
    chk("t4_rx_valid", rx_valid, 1);
    drain();

    // Reset released in the middle of a foreign frame
    rst_n = 1'b0;
    cs_n = 1'b0;
    wait_clk(2);
    rst_n = 1'b1;
    fs0 = fs_cnt;
    spi_xfer(8'hC3, 8, mi0); spi_xfer(8'hFF, 8, mi0);
    chk("t5_ignored_rx_valid", rx_valid, 0);
    chk("t5_ignored_frame", fs_cnt - fs0, 0);
    cs_n = 1'b1;
    wait_clk(6);
    cs_low(); spi_xfer(8'h5A, 8, mi0); cs_high();
    chk("t5_rx_data", rx_data, 8'h5A);
    chk("t5_rx_valid", rx_valid, 1);
    chk("t5_frame_start", fs_cnt - fs0, 1);
    drain();

    // Streaming both directions back to back
    rxn0 = rx_n; un0 = un_cnt; ov0 = ov_cnt;
    tx_base = tx_sent;
    rx_ready = 1'b1;
    auto_tx = 1'b1;
    wait_clk(3);
    cs_low(); spi_xfer(8'h01, 8, mi0); spi_xfer(8'h02, 8, mi1); spi_xfer(8'h03, 8, mi2); cs_high();
    auto_tx = 1'b0;
    rx_ready = 1'b0;
    chk("t6_miso_b0", mi0, 8'h01);
    chk("t6_miso_b1", mi1, 8'h02);
    chk("t6_miso_b2", mi2, 8'h03);
    chk("t6_rx_count", rx_n - rxn0, 3);
    chk("t6_rx_b0", rx_log[rxn0], 8'h01);
    chk("t6_rx_b1", rx_log[rxn0+1], 8'h02);
    chk("t6_rx_b2", rx_log[rxn0+2], 8'h03);
    chk("t6_no_underrun", un_cnt - un0, 0);
    chk("t6_no_overrun", ov_cnt - ov0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
